matriz_soma_ctrl: RTL and testbench
===================================

Name: matriz_soma_ctrl

Overview:
- Sequencer for the 5x5 signed 8-bit matrix adder in the ULA.
- Loads matrix A, then matrix B, one 40-bit row per handshake from the row bus, and drives the adder operands.
- Captures the sum and the overflow flag in one execute cycle.
- Streams the result back row by row.
- Sits between the coprocessor instruction/memory interface and the combinational adder, which is instantiated outside this block.

Parameters:
- ROWS, 5, number of matrix rows.
- COLS, 5, elements per row.
- ELEM_W, 8, element width in bits, two's complement.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin an operation; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- in_data  in  COLS*ELEM_W  operand row; element 0 occupies bits [ELEM_W-1:0].
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a row this cycle.
- ula_a  out  ROWS*COLS*ELEM_W  registered operand A to the adder.
- ula_b  out  ROWS*COLS*ELEM_W  registered operand B to the adder.
- ula_resultado  in  ROWS*COLS*ELEM_W  adder sum.
- ula_overflow  in  1  adder overflow flag.
- out_data  out  COLS*ELEM_W  result row.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the row.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last result row is accepted.
- overflow  out  1  overflow status of the last operation.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE; row counter goes to 0.
  - ula_a, ula_b, out_data and the result register go to 0.
  - in_ready, out_valid, busy, done and overflow go to 0.
- States: IDLE, LOAD_A, LOAD_B, EXEC, OUT.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 clears the row counter and overflow, then enters LOAD_A at the next edge.
- LOAD_A:
  - in_ready=1.
  - On in_valid&in_ready, row r is written to ula_a[r*COLS*ELEM_W +: COLS*ELEM_W] and r increments.
  - Acceptance with r=ROWS-1 sets r=0 and enters LOAD_B.
  - in_valid=0 holds state; there is no timeout.
- LOAD_B: identical to LOAD_A but writes ula_b; the last row enters EXEC.
- EXEC:
  - Exactly one cycle; in_ready=0.
  - ula_resultado is registered into the result register and ula_overflow into overflow.
  - Enters OUT.
- OUT:
  - out_valid=1; out_data = result row r.
  - out_data and out_valid stay stable while out_ready=0.
  - On out_valid&out_ready, r increments.
  - Acceptance of row ROWS-1 makes done=1 for the next cycle, returns to IDLE and sets r=0.
- Latency:
  - start at edge t gives in_ready=1 at t+1.
  - Last B row accepted at edge t gives EXEC during t+1 and first out_valid at t+2.
  - Minimum operation is 1 + 5 + 5 + 1 + 5 = 17 cycles with continuous valid/ready.
- ula_a and ula_b hold their values after the operation until they are overwritten.
- overflow holds from EXEC until the next accepted start.
- start outside IDLE is ignored.
- abort=1:
  - Next state is IDLE; r=0; in_ready and out_valid drop.
  - done is not pulsed; overflow is cleared.
  - abort takes priority over start and over simultaneous handshakes.
- A row is consumed only on the edge where valid and ready are both high; there is no combinational path from in_valid to in_ready.
- Arithmetic lives in the adder:
  - Per-element wrap-around modulo 2^ELEM_W.
  - Overflow is the OR over all elements of (signA==signB) and (signSum!=signA), using each element's MSB at index i*ELEM_W+ELEM_W-1.

Test Plan:
- Basic add:
  - Stimulus: reset, then start; A all elements 0x03, B all elements 0x04, continuous valid/ready.
  - Required: five out rows of 0x0404040404 + 0x0303030303 = 0x0707070707; overflow=0; done pulse at cycle 17 after start; busy low after.
- Positive overflow:
  - Stimulus: A element 12 = 0x7F, B element 12 = 0x01, all other elements 0.
  - Required: row 2 out = 0x0000800000 (element 12 = 0x80); overflow=1 until the next start; the next clean operation clears it.
- Negative wrap without overflow:
  - Stimulus: A all elements 0xFF, B all elements 0x01.
  - Required: all out rows 0x0000000000; overflow=0.
- Backpressure and gaps:
  - Stimulus: in_valid toggled every other cycle; out_ready low for 3 cycles on row 1.
  - Required: out_data holds row 1 stable; no row is skipped or duplicated; results are identical to the basic add.
- Abort mid-operation:
  - Stimulus: abort after 2 rows of B.
  - Required: IDLE next cycle; in_ready=0, busy=0, no done pulse; the following full operation produces correct results.
- Asynchronous reset during OUT:
  - Stimulus: rst_n low mid-cycle while out_valid=1.
  - Required: all outputs go to 0 immediately, without waiting for a clock edge; start is ignored while rst_n=0.

Source files
------------

// File: rtl/matriz_soma_if.sv
// Row-bus handshake bundle for the matrix adder sequencer.
// master drives operand rows and accepts results; slave is the sequencer.
interface matriz_soma_if #(
  parameter int ROW_W = 40
);
  logic [ROW_W-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [ROW_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/matriz_soma_ctrl.sv
// Sequencer for the 5x5 signed matrix adder: loads A and B row by row,
// latches the external adder's sum and overflow, then streams the result.
module matriz_soma_ctrl #(
  parameter int ROWS   = 5,
  parameter int COLS   = 5,
  parameter int ELEM_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  matriz_soma_if.slave                bus,
  output logic [ROWS*COLS*ELEM_W-1:0] ula_a,
  output logic [ROWS*COLS*ELEM_W-1:0] ula_b,
  input  logic [ROWS*COLS*ELEM_W-1:0] ula_resultado,
  input  logic                        ula_overflow,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow
);

  localparam int ROW_W = COLS * ELEM_W;
  localparam int MAT_W = ROWS * ROW_W;
  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, EXEC, OUT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] r_q, r_d;
  logic [MAT_W-1:0] a_q, a_d;
  logic [MAT_W-1:0] b_q, b_d;
  logic [MAT_W-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic in_rdy;
  logic out_vld;
  logic in_fire;
  logic out_fire;
  logic last_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    // abort wins over start and over any handshake in flight
    if (abort) begin
      state_d = IDLE;
      r_d     = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = LOAD_A;
            r_d     = '0;
            ovf_d   = 1'b0;
          end
        end
        LOAD_A: begin
          if (in_fire) begin
            a_d[r_q*ROW_W +: ROW_W] = bus.in_data;
            if (last_row) begin
              r_d     = '0;
              state_d = LOAD_B;
            end else begin
              r_d = r_q + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (in_fire) begin
            b_d[r_q*ROW_W +: ROW_W] = bus.in_data;
            if (last_row) begin
              r_d     = '0;
              state_d = EXEC;
            end else begin
              r_d = r_q + 1'b1;
            end
          end
        end
        EXEC: begin
          res_d   = ula_resultado;
          ovf_d   = ula_overflow;
          state_d = OUT;
        end
        OUT: begin
          if (out_fire) begin
            if (last_row) begin
              r_d     = '0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              r_d = r_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_rdy   = (state_q == LOAD_A) || (state_q == LOAD_B);
    out_vld  = (state_q == OUT);
    in_fire  = in_rdy & bus.in_valid;
    out_fire = out_vld & bus.out_ready;
    last_row = (r_q == CNT_W'(ROWS - 1));
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_data  = res_q[r_q*ROW_W +: ROW_W];
  assign ula_a         = a_q;
  assign ula_b         = b_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_matriz_soma_ctrl.sv
// Bench for matriz_soma_ctrl: behavioural adder + matrix model,
// directed operations with gaps, stalls, abort and async reset.
module tb_matriz_soma_ctrl;

  localparam int R  = 5;
  localparam int C  = 5;
  localparam int W  = 8;
  localparam int N  = R * C;
  localparam int RW = C * W;
  localparam int MW = R * RW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [MW-1:0] ula_a, ula_b, ula_res;
  logic ula_ovf, busy, done, overflow;

  always #5 clk = ~clk;

  matriz_soma_if #(.ROW_W(RW)) bus ();

  matriz_soma_ctrl #(.ROWS(R), .COLS(C), .ELEM_W(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .bus           (bus),
    .ula_a         (ula_a),
    .ula_b         (ula_b),
    .ula_resultado (ula_res),
    .ula_overflow  (ula_ovf),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow)
  );

  // external combinational adder the sequencer drives
  logic [N-1:0] elem_ovf;
  for (genvar g = 0; g < N; g++) begin : g_add
    wire [W-1:0] ea = ula_a[g*W +: W];
    wire [W-1:0] eb = ula_b[g*W +: W];
    wire [W-1:0] es = ea + eb;
    assign ula_res[g*W +: W] = es;
    assign elem_ovf[g] = (ea[W-1] == eb[W-1]) && (es[W-1] != ea[W-1]);
  end
  assign ula_ovf = |elem_ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int out_idx = 0;
  int done_cnt = 0;

  logic [W-1:0]  ma [N];
  logic [W-1:0]  mb [N];
  logic [RW-1:0] exp_row [R];
  logic          exp_ovf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic build_model();
    int s;
    exp_ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      s = int'($signed(ma[i])) + int'($signed(mb[i]));
      if (s > 127 || s < -128) exp_ovf = 1'b1;
      exp_row[i / C][(i % C)*W +: W] = W'(s);
    end
  endtask

  function automatic logic [RW-1:0] a_row(input int r);
    logic [RW-1:0] v;
    for (int j = 0; j < C; j++) v[j*W +: W] = ma[r*C + j];
    return v;
  endfunction

  function automatic logic [RW-1:0] b_row(input int r);
    logic [RW-1:0] v;
    for (int j = 0; j < C; j++) v[j*W +: W] = mb[r*C + j];
    return v;
  endfunction

  // result stream must match the model row the consumer is waiting for
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (out_idx < R) chk("out_row", 64'(bus.out_data), 64'(exp_row[out_idx]));
      else chk("out_extra_row", 64'(out_idx), 64'(R - 1));
    end
    if (rst_n && done) done_cnt++;
  end

  task automatic start_op();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_cyc = cyc;
    out_idx = 0;
    chk("in_ready_after_start", 64'(bus.in_ready), 64'd1);
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic send_row(input logic [RW-1:0] d, input bit gap);
    bit rdy;
    int n = 0;
    if (gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    forever begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = d;
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) break;
      if (++n > 50) begin
        chk("in_timeout", 64'd1, 64'd0);
        break;
      end
    end
  endtask

  task automatic recv_row(input int stall);
    bit v;
    int n = 0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
    end
    forever begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      v = bus.out_valid;
      @(posedge clk);
      if (v) begin
        out_idx++;
        break;
      end
      if (++n > 50) begin
        chk("out_timeout", 64'd1, 64'd0);
        break;
      end
    end
  endtask

  task automatic load_all(input bit gap);
    for (int r = 0; r < R; r++) send_row(a_row(r), gap);
    for (int r = 0; r < R; r++) send_row(b_row(r), gap);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_op(input bit gap, input int stall_row, input bit timed);
    build_model();
    start_op();
    load_all(gap);
    for (int k = 0; k < R; k++) recv_row(k == stall_row ? 3 : 0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
    chk("overflow_end", 64'(overflow), 64'(exp_ovf));
    chk("rows_seen", 64'(out_idx), 64'(R));
    if (timed) chk("done_cycle", 64'(cyc - start_cyc), 64'd16);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic fill(input logic [W-1:0] va, input logic [W-1:0] vb);
    for (int i = 0; i < N; i++) begin
      ma[i] = va;
      mb[i] = vb;
    end
  endtask

  initial begin
    int dc;
    logic [MW-1:0] a3, b4;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    #22;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_ula_a", 64'(ula_a[63:0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    fill(8'h03, 8'h04);
    build_model();
    chk("model_basic_row", 64'(exp_row[0]), 64'h0707070707);
    run_op(1'b0, -1, 1'b1);
    a3 = {N{8'h03}};
    b4 = {N{8'h04}};
    chk("ula_a_held", 64'(ula_a == a3), 64'd1);
    chk("ula_b_held", 64'(ula_b == b4), 64'd1);

    fill(8'h00, 8'h00);
    ma[12] = 8'h7F;
    mb[12] = 8'h01;
    build_model();
    chk("model_ovf_row2", 64'(exp_row[2]), 64'h0000800000);
    chk("model_ovf_flag", 64'(exp_ovf), 64'd1);
    run_op(1'b0, -1, 1'b1);
    repeat (3) @(negedge clk);
    chk("overflow_held", 64'(overflow), 64'd1);

    fill(8'hFF, 8'h01);
    build_model();
    chk("model_wrap_row", 64'(exp_row[4]), 64'h0);
    run_op(1'b0, -1, 1'b1);
    chk("overflow_cleared", 64'(overflow), 64'd0);

    fill(8'h03, 8'h04);
    run_op(1'b1, 1, 1'b0);

    // abort with a B row handshake pending on the same edge
    fill(8'h11, 8'h22);
    build_model();
    start_op();
    for (int r = 0; r < R; r++) send_row(a_row(r), 1'b0);
    for (int r = 0; r < 2; r++) send_row(b_row(r), 1'b0);
    dc = done_cnt;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = b_row(2);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_overflow", 64'(overflow), 64'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(dc));
    run_op(1'b0, -1, 1'b1);

    // async reset while a result row is being offered
    for (int i = 0; i < N; i++) begin
      ma[i] = W'(i * 9 + 1);
      mb[i] = W'(200 - i * 7);
    end
    build_model();
    start_op();
    load_all(1'b0);
    recv_row(0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_data", 64'(bus.out_data), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_overflow", 64'(overflow), 64'd0);
    chk("arst_ula_b_zero", 64'(ula_b == '0), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("arst_start_ignored", 64'(busy), 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle_after", 64'(busy), 64'd0);
    run_op(1'b1, 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
